running_sum_decoder: RTL and testbench

// Receive-side inverse of the running-average filter. Consumes the N-tap window-sum

---
 rtl/running_avg_pkg.sv | 14 +
 rtl/sample_window.sv | 29 ++
 rtl/running_sum_decoder.sv | 100 ++++++++++
 tb/tb_running_sum_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/running_avg_pkg.sv
// Shared types for the running-average filter and its receive-side decoder.
package running_avg_pkg;

  localparam int unsigned DEFAULT_N         = 4;
  localparam int unsigned DEFAULT_DATAWIDTH = 32;

  typedef logic [DEFAULT_DATAWIDTH-1:0] sample_t;

  typedef enum logic [0:0] {
    FILL,
    STEADY
  } dec_state_e;

endpackage

// File: rtl/sample_window.sv
// Enable-shifted N-deep sample delay line; tap_o is the oldest held sample.
module sample_window #(
  parameter int unsigned N         = 4,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [DATAWIDTH-1:0] din_i,
  output logic [DATAWIDTH-1:0] tap_o
);

  logic [DATAWIDTH-1:0] hist_q [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N); i++) hist_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(N); i++) hist_q[i] <= '0;
    end else if (en_i) begin
      hist_q[0] <= din_i;
      for (int i = 1; i < int'(N); i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign tap_o = hist_q[N-1];

endmodule

// File: rtl/running_sum_decoder.sv
// Reconstructs samples from an N-tap window-sum stream: x[n] = S[n] - S[n-1] + x[n-N].
module running_sum_decoder
  import running_avg_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter int unsigned DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 sum_valid_i,
  output logic                 sum_ready_o,
  input  logic [DATAWIDTH-1:0] sum_i,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 warm_o
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [DATAWIDTH-1:0] sum_prev_q;
  logic [DATAWIDTH-1:0] data_q;
  logic [DATAWIDTH-1:0] tap;
  logic [DATAWIDTH-1:0] x;
  logic                 valid_q;
  logic                 warm_q;
  logic                 accept;
  logic [CW-1:0]        count_q;
  dec_state_e           state_q;

  // Ready whenever the output slot is empty or drains this cycle.
  assign sum_ready_o = !valid_q || data_ready_i;
  assign accept      = sum_valid_i && sum_ready_o && !clear_i;
  assign x           = sum_i - sum_prev_q + tap;

  sample_window #(
    .N         (N),
    .DATAWIDTH (DATAWIDTH)
  ) u_window (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear_i),
    .en_i    (accept),
    .din_i   (x),
    .tap_o   (tap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_prev_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else if (clear_i) begin
      sum_prev_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else if (accept) begin
      sum_prev_q <= sum_i;
      data_q     <= x;
      valid_q    <= 1'b1;
    end else if (data_ready_i) begin
      valid_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      count_q <= '0;
      warm_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= FILL;
      count_q <= '0;
      warm_q  <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (count_q == CW'(N - 1)) begin
              state_q <= STEADY;
              count_q <= CW'(N);
              warm_q  <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        STEADY: begin
          warm_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_valid_o = valid_q;
  assign data_o       = data_q;
  assign warm_o       = warm_q;

endmodule

// File: tb/tb_running_sum_decoder.sv
// Self-checking bench for running_sum_decoder (N=4, DATAWIDTH=32).
module tb_running_sum_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_i;
  logic        sum_valid_i;
  logic        sum_ready_o;
  logic [31:0] sum_i;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [31:0] data_o;
  logic        warm_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  running_sum_decoder #(
    .N         (4),
    .DATAWIDTH (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear_i),
    .sum_valid_i  (sum_valid_i),
    .sum_ready_o  (sum_ready_o),
    .sum_i        (sum_i),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_o       (data_o),
    .warm_o       (warm_o)
  );

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    reset_n      = 1'b0;
    clear_i      = 1'b0;
    sum_valid_i  = 1'b0;
    sum_i        = '0;
    data_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    clear_i      = 1'b0;
    sum_valid_i  = 1'b0;
    sum_i        = '0;
    data_ready_i = 1'b0;
    #1;
    total++;
    if (data_valid_o !== 1'b0 || data_o !== 32'd0 || warm_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_held valid=%b data=%h warm=%b required 0 0 0",
               data_valid_o, data_o, warm_o);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (data_valid_o !== 1'b0 || data_o !== 32'd0 || warm_o !== 1'b0 || sum_ready_o !== 1'b1)
    begin
      bad++;
      $display("FAIL reset_release valid=%b data=%h warm=%b ready=%b required 0 0 0 1",
               data_valid_o, data_o, warm_o, sum_ready_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] s [5];
    logic [31:0] e [5];
    s = '{32'd5, 32'd12, 32'd21, 32'd32, 32'd39};
    e = '{32'd5, 32'd7, 32'd9, 32'd11, 32'd12};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sum_valid_i  = 1'b1;
      sum_i        = s[i];
      data_ready_i = 1'b1;
      #1;
      total++;
      if (sum_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL basic_ready[%0d] got=%b required=1", i, sum_ready_o);
      end
      @(posedge clk);
      #1;
      total++;
      if (data_valid_o !== 1'b1 || data_o !== e[i] || warm_o !== (i >= 3)) begin
        bad++;
        $display("FAIL basic_out[%0d] valid=%b data=%0d warm=%b required 1 %0d %b",
                 i, data_valid_o, data_o, warm_o, e[i], (i >= 3));
      end
    end
    sum_valid_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (data_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain valid=%b required=0", data_valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s [5];
    logic [31:0] e [5];
    s = '{32'd5, 32'd12, 32'd21, 32'd32, 32'd39};
    e = '{32'd5, 32'd7, 32'd9, 32'd11, 32'd12};
    do_reset();
    sum_valid_i = 1'b1;
    sum_i       = s[0];
    @(posedge clk);
    #1;
    data_ready_i = 1'b0;
    sum_i        = s[1];
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (sum_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready[%0d] got=%b required=0", c, sum_ready_o);
      end
      @(posedge clk);
      #1;
      total++;
      if (data_valid_o !== 1'b1 || data_o !== 32'd5) begin
        bad++;
        $display("FAIL bp_hold[%0d] valid=%b data=%0d required 1 5", c, data_valid_o, data_o);
      end
    end
    data_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      sum_i = s[i];
      @(posedge clk);
      #1;
      total++;
      if (data_valid_o !== 1'b1 || data_o !== e[i]) begin
        bad++;
        $display("FAIL bp_out[%0d] valid=%b data=%0d required 1 %0d",
                 i, data_valid_o, data_o, e[i]);
      end
    end
    sum_valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] s [2];
    logic [31:0] e [2];
    s = '{32'hFFFF_FFFF, 32'h0000_0001};
    e = '{32'hFFFF_FFFF, 32'h0000_0002};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sum_valid_i = 1'b1;
      sum_i       = s[i];
      @(posedge clk);
      #1;
      total++;
      if (data_valid_o !== 1'b1 || data_o !== e[i]) begin
        bad++;
        $display("FAIL wrap[%0d] valid=%b data=%h required 1 %h", i, data_valid_o, data_o, e[i]);
      end
    end
    sum_valid_i = 1'b0;
  endtask

  task automatic test_clear();
    logic [31:0] s [4];
    s = '{32'd5, 32'd12, 32'd21, 32'd32};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sum_valid_i = 1'b1;
      sum_i       = s[i];
      @(posedge clk);
      #1;
    end
    total++;
    if (warm_o !== 1'b1 || data_o !== 32'd11) begin
      bad++;
      $display("FAIL clear_pre warm=%b data=%0d required 1 11", warm_o, data_o);
    end
    clear_i = 1'b1;
    sum_i   = 32'd44;
    @(posedge clk);
    #1;
    total++;
    if (data_valid_o !== 1'b0 || warm_o !== 1'b0 || data_o !== 32'd0) begin
      bad++;
      $display("FAIL clear_drop valid=%b warm=%b data=%0d required 0 0 0",
               data_valid_o, warm_o, data_o);
    end
    clear_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (data_valid_o !== 1'b1 || data_o !== 32'd44 || warm_o !== 1'b0) begin
      bad++;
      $display("FAIL clear_reoffer valid=%b data=%0d warm=%b required 1 44 0",
               data_valid_o, data_o, warm_o);
    end
    sum_valid_i = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] s [5];
    logic [31:0] e [5];
    s = '{32'd5, 32'd12, 32'd21, 32'd32, 32'd39};
    e = '{32'd5, 32'd7, 32'd9, 32'd11, 32'd12};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sum_valid_i = 1'b1;
      sum_i       = s[i];
      @(posedge clk);
      #1;
    end
    sum_valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (data_valid_o !== 1'b0 || data_o !== 32'd0 || warm_o !== 1'b0) begin
      bad++;
      $display("FAIL async_drop valid=%b data=%0d warm=%b required 0 0 0",
               data_valid_o, data_o, warm_o);
    end
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      sum_valid_i = 1'b1;
      sum_i       = s[i];
      @(posedge clk);
      #1;
      total++;
      if (data_valid_o !== 1'b1 || data_o !== e[i] || warm_o !== (i >= 3)) begin
        bad++;
        $display("FAIL async_restart[%0d] valid=%b data=%0d warm=%b required 1 %0d %b",
                 i, data_valid_o, data_o, warm_o, e[i], (i >= 3));
      end
    end
    sum_valid_i = 1'b0;
  endtask

  // Filter model: each sum is the plain total of the last four samples (zeros before start).
  task automatic test_closed_loop();
    localparam int NS = 10000;
    logic [31:0] xs   [$];
    logic [31:0] sums [$];
    logic [31:0] acc;
    int          sent   = 0;
    int          got    = 0;
    int          cycles = 0;
    bit          took;
    for (int i = 0; i < NS; i++) begin
      xs.push_back($urandom);
      acc = '0;
      for (int k = 0; k < 4; k++) if (i - k >= 0) acc = acc + xs[i-k];
      sums.push_back(acc);
    end
    do_reset();
    while (got < NS && cycles < 60000) begin
      if (!sum_valid_i && sent < NS && $urandom_range(3) != 0) begin
        sum_valid_i = 1'b1;
        sum_i       = sums[sent];
      end
      data_ready_i = ($urandom_range(3) != 0);
      #1;
      took = sum_valid_i && sum_ready_o;
      if (data_valid_o && data_ready_i) begin
        total++;
        if (data_o !== xs[got]) begin
          bad++;
          $display("FAIL loop_sample[%0d] got=%h required=%h", got, data_o, xs[got]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (took) begin
        sent++;
        sum_valid_i = 1'b0;
      end
      cycles++;
    end
    total++;
    if (got != NS) begin
      bad++;
      $display("FAIL loop_count got=%0d required=%0d", got, NS);
    end
    sum_valid_i  = 1'b0;
    data_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_clear();
    test_async_reset();
    test_closed_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
